// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to TRIGGER_ADDR stalls the core and copies page $PP00-$PPFF to DEST_ADDR.
// Optional macro OAM_DMA_ALIGN_EN adds get/put parity alignment (513/514-cycle stall, else always 513).
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_din,
  output logic        rdy,
  output logic        dma_own,
  output logic        busy,
  output logic [15:0] bus_a,
  output logic        bus_rw,
  output logic [7:0]  bus_dout
);

  typedef enum logic [2:0] {IDLE, PEND, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  page, idx, byte_lat;
  logic [15:0] dma_a;
  logic        dma_rw;
  logic        trig;
  logic        halt_to_read;

  assign trig = !cpu_rw && (cpu_a == TRIGGER_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= 1'b0;
    else     parity <= ~parity;
  end

  // Parity is 1 now means the next cycle is a get cycle, so READ can start immediately.
  assign halt_to_read = parity;
`else
  assign halt_to_read = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    dma_own   = 1'b0;
    dma_a     = DEST_ADDR;
    dma_rw    = 1'b1;
    case (state)
      IDLE:  if (trig) state_nxt = PEND;
      PEND:  if (cpu_rw) state_nxt = HALT;
      HALT:  state_nxt = halt_to_read ? READ : ALIGN;
      ALIGN: begin
        dma_own   = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        dma_own   = 1'b1;
        dma_a     = {page, idx};
        state_nxt = WRITE;
      end
      WRITE: begin
        dma_own   = 1'b1;
        dma_rw    = 1'b0;
        state_nxt = (idx == 8'hFF) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign rdy      = (state == IDLE);
  assign bus_a    = dma_own ? dma_a    : cpu_a;
  assign bus_rw   = dma_own ? dma_rw   : cpu_rw;
  assign bus_dout = dma_own ? byte_lat : cpu_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      page     <= 8'h00;
      idx      <= 8'h00;
      byte_lat <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (trig) begin
          page <= cpu_dout;
          idx  <= 8'h00;
        end
        // A stray trigger while pending only relatches the page.
        PEND:  if (trig) page <= cpu_dout;
        READ:  byte_lat <= bus_din;
        WRITE: idx <= (idx == 8'hFF) ? 8'h00 : idx + 8'h01;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: random page contents and pages, expected bus cycles built as a queue from the transfer rules.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_a = 16'h8000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  bus_din;
  logic        rdy, dma_own, busy, bus_rw;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;

  logic [7:0]  mem [256];
  int unsigned ecount;
  int          total = 0;
  int          passed = 0;

  typedef struct packed {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
  } cyc_t;
  cyc_t q[$];

  oam_dma dut (
    .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw),
    .bus_din(bus_din), .rdy(rdy), .dma_own(dma_own), .busy(busy),
    .bus_a(bus_a), .bus_rw(bus_rw), .bus_dout(bus_dout)
  );

  always #5 clk = ~clk;

  // System memory: the byte returned depends on both page and offset.
  assign bus_din = mem[bus_a[7:0]] ^ bus_a[15:8];

  // Edge count since reset; its LSB is the current get/put parity.
  always @(posedge clk or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_a    = 16'h8000;
    cpu_rw   = 1'b1;
    cpu_dout = 8'h00;
  endtask

  task automatic run_dma(input logic [7:0] pg, input int nw, input bit want_h);
    int   low;
    int   exp_len;
    bit   done;
    cyc_t e;
    cpu_idle();
    for (int k = 0; k < 4 && ecount[0] != (want_h ^ nw[0]); k++) step();
    cpu_a = 16'h4014; cpu_rw = 1'b0; cpu_dout = (nw > 0) ? (pg ^ 8'h55) : pg;
    step();
    check("pend_busy", busy, 1);
    check("pend_rdy", rdy, 0);
    for (int i = 0; i < nw; i++) begin
      // First extra write retargets the page; the rest hit ordinary addresses.
      cpu_a    = (i == 0) ? 16'h4014 : 16'h0100 + 16'(i);
      cpu_rw   = 1'b0;
      cpu_dout = (i == 0) ? pg : 8'($urandom);
      #1;
      check("pend_wr_own", dma_own, 0);
      check("pend_wr_a", bus_a, cpu_a);
      check("pend_wr_rw", bus_rw, 0);
      check("pend_wr_dout", bus_dout, cpu_dout);
      step();
      check("pend_wr_state", busy, 1);
    end
    cpu_idle();
    step();
    check("halt_own", dma_own, 0);
    check("halt_rdy", rdy, 0);
    check("halt_a", bus_a, 16'h8000);
    q.delete();
`ifdef OAM_DMA_ALIGN_EN
    if (!ecount[0]) q.push_back('{a: 16'h2004, rw: 1'b1, d: 8'h00});
`endif
    for (int i = 0; i < 256; i++) begin
      q.push_back('{a: {pg, 8'(i)}, rw: 1'b1, d: 8'h00});
      q.push_back('{a: 16'h2004, rw: 1'b0, d: mem[i] ^ pg});
    end
    exp_len = 1 + q.size();
    low  = 1;
    done = 0;
    for (int c = 0; c < 700 && !done; c++) begin
      step();
      if (rdy) done = 1;
      else begin
        low++;
        if (!dma_own || q.size() == 0) check("dma_cycle_expected", dma_own, q.size() != 0);
        else begin
          e = q.pop_front();
          if (bus_a !== e.a || bus_rw !== e.rw || (!e.rw && bus_dout !== e.d)) begin
            check("dma_bus_a", bus_a, e.a);
            check("dma_bus_rw", bus_rw, e.rw);
            if (!e.rw) check("dma_bus_dout", bus_dout, e.d);
          end
        end
      end
    end
    check("stall_len", low, exp_len);
    check("queue_drained", q.size(), 0);
    check("end_busy", busy, 0);
    check("end_own", dma_own, 0);
    check("end_bus_a", bus_a, cpu_a);
  endtask

  initial begin
    int wcount;
    int stray;
    logic [7:0] pg;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #12;
    check("rst_rdy", rdy, 1);
    check("rst_own", dma_own, 0);
    check("rst_busy", busy, 0);
    check("rst_bus_a", bus_a, 16'h8000);
    check("rst_bus_rw", bus_rw, 1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Accesses that must not trigger.
    cpu_a = 16'h4015; cpu_rw = 1'b0; cpu_dout = 8'h02;
    #1;
    check("wr4015_pass_a", bus_a, 16'h4015);
    check("wr4015_pass_dout", bus_dout, 8'h02);
    step();
    check("wr4015_busy", busy, 0);
    check("wr4015_rdy", rdy, 1);
    cpu_a = 16'h4014; cpu_rw = 1'b1;
    step();
    check("rd4014_busy", busy, 0);
    check("rd4014_rdy", rdy, 1);

    run_dma(8'h02, 0, 1'b1);
    run_dma(8'h02, 0, 1'b0);
    pg = 8'($urandom);
    run_dma(pg, 2, 1'b1);
    pg = 8'($urandom);
    run_dma(pg, 1, 1'b0);

    // Reset during the WRITE of idx 8'h40.
    cpu_idle();
    cpu_a = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h03;
    step();
    cpu_idle();
    wcount = 0;
    for (int c = 0; c < 400 && wcount < 8'h41; c++) begin
      step();
      if (dma_own && bus_rw == 1'b0) wcount++;
    end
    check("rst_mid_reached", wcount, 32'h41);
    check("rst_mid_wr_a", bus_a, 16'h2004);
    rst = 1'b1;
    #1;
    check("rst_mid_rdy", rdy, 1);
    check("rst_mid_own", dma_own, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_bus_a", bus_a, cpu_a);
    step();
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (dma_own || bus_a == 16'h2004) stray++;
    end
    check("rst_mid_no_dma", stray, 0);
    check("rst_mid_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
